// File: rtl/ps2_key_event_fifo.sv
// Set-2 PS/2 byte decoder feeding a show-ahead key-event FIFO with valid/ready pop.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses typematic repeats of the held key.
module ps2_key_event_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            evt_code,
  output logic                  evt_ext,
  output logic                  evt_break,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clear_ovf,
  output logic [7:0]            last_code
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_E0   = 3'd1,
    S_F0   = 3'd2,
    S_E0F0 = 3'd3,
    S_SKIP = 3'd4
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [2:0]            skip_r, skip_nxt_s;
  logic                  emit_s, emit_ext_s, emit_brk_s;
  logic                  repeat_s, push_s, make_s;
  logic                  pop_s, full_s, wr_s, drop_s;
  logic [DEPTH_LOG2:0]   wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s, count_nxt_s;
  logic [9:0]            mem_r [DEPTH];
  logic [9:0]            push_data_s, head_nxt_s;

  // Status and ack bytes the keyboard sends outside of key sequences.
  function automatic logic is_dropped(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFD, 8'h00, 8'hFF: is_dropped = 1'b1;
      default:                                          is_dropped = 1'b0;
    endcase
  endfunction

  // Prefix decoder: next state, pause skip count and event emission.
  always_comb begin
    state_nxt_s = state_r;
    skip_nxt_s  = skip_r;
    emit_s      = 1'b0;
    emit_ext_s  = 1'b0;
    emit_brk_s  = 1'b0;
    if (rx_valid) begin
      case (state_r)
        S_IDLE: begin
          if (rx_data == 8'hE0) begin
            state_nxt_s = S_E0;
          end else if (rx_data == 8'hF0) begin
            state_nxt_s = S_F0;
          end else if (rx_data == 8'hE1) begin
            state_nxt_s = S_SKIP;
            skip_nxt_s  = 3'd7;
          end else if (is_dropped(rx_data)) begin
            state_nxt_s = S_IDLE;
          end else begin
            emit_s = 1'b1;
          end
        end
        S_E0: begin
          if (rx_data == 8'hF0) begin
            state_nxt_s = S_E0F0;
          end else if (rx_data == 8'hE0) begin
            state_nxt_s = S_E0;
          end else begin
            emit_s      = 1'b1;
            emit_ext_s  = 1'b1;
            state_nxt_s = S_IDLE;
          end
        end
        S_F0: begin
          emit_s      = 1'b1;
          emit_brk_s  = 1'b1;
          state_nxt_s = S_IDLE;
        end
        S_E0F0: begin
          emit_s      = 1'b1;
          emit_ext_s  = 1'b1;
          emit_brk_s  = 1'b1;
          state_nxt_s = S_IDLE;
        end
        S_SKIP: begin
          skip_nxt_s = skip_r - 3'd1;
          if (skip_r <= 3'd1) begin
            state_nxt_s = S_IDLE;
            skip_nxt_s  = 3'd0;
          end else begin
            state_nxt_s = S_SKIP;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
          skip_nxt_s  = 3'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_r;
  logic [7:0] held_code_r;
  logic       held_ext_r;

  assign repeat_s = emit_s && !emit_brk_s && held_r &&
                    (held_code_r == rx_data) && (held_ext_r == emit_ext_s);

  // Tracks the key currently held down so auto-repeat makes can be filtered.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      held_r      <= 1'b0;
      held_code_r <= 8'h00;
      held_ext_r  <= 1'b0;
    end else if (emit_s && !emit_brk_s && !repeat_s) begin
      held_r      <= 1'b1;
      held_code_r <= rx_data;
      held_ext_r  <= emit_ext_s;
    end else if (emit_s && emit_brk_s && held_r &&
                 (held_code_r == rx_data) && (held_ext_r == emit_ext_s)) begin
      held_r <= 1'b0;
    end
  end
`else
  assign repeat_s = 1'b0;
`endif

  assign push_s      = emit_s && !repeat_s;
  assign make_s      = push_s && !emit_brk_s;
  assign push_data_s = {rx_data, emit_ext_s, emit_brk_s};

  // Full when the wrap bits differ and the index bits match; a same-cycle pop frees a slot.
  assign pop_s       = evt_valid && evt_ready;
  assign full_s      = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                       (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
  assign wr_s        = push_s && (!full_s || pop_s);
  assign drop_s      = push_s && full_s && !pop_s;
  assign wr_nxt_s    = wr_ptr_r + {{DEPTH_LOG2{1'b0}}, wr_s};
  assign rd_nxt_s    = rd_ptr_r + {{DEPTH_LOG2{1'b0}}, pop_s};
  assign count_nxt_s = wr_nxt_s - rd_nxt_s;
  assign head_nxt_s  = (wr_s && (wr_ptr_r == rd_nxt_s)) ? push_data_s
                                                        : mem_r[rd_nxt_s[DEPTH_LOG2-1:0]];

  // Event storage.
  always_ff @(posedge CLOCK_50) begin
    if (wr_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= push_data_s;
    end
  end

  // Decoder state, pointers and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r   <= S_IDLE;
      skip_r    <= 3'd0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count     <= '0;
      evt_valid <= 1'b0;
      evt_code  <= 8'h00;
      evt_ext   <= 1'b0;
      evt_break <= 1'b0;
      overflow  <= 1'b0;
      last_code <= 8'h00;
    end else begin
      state_r   <= state_nxt_s;
      skip_r    <= skip_nxt_s;
      wr_ptr_r  <= wr_nxt_s;
      rd_ptr_r  <= rd_nxt_s;
      count     <= count_nxt_s;
      evt_valid <= (count_nxt_s != '0);
      if (count_nxt_s != '0) begin
        {evt_code, evt_ext, evt_break} <= head_nxt_s;
      end
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
      if (make_s) begin
        last_code <= rx_data;
      end
    end
  end

endmodule

// File: doc/ps2_key_event_fifo.md
# ps2_key_event_fifo

Parametrised successor to the single-byte keyboard capture stage. Consumes the raw byte strobe from the PS/2 controller, decodes Set-2 prefixes (E0, F0, E1 pause) into make/break key events, and buffers them in a show-ahead FIFO with a valid/ready pop handshake. It sits between the PS/2 controller and the paint command logic, so keystrokes are no longer lost when the consumer is busy.

## Interface
- DEPTH_LOG2, 3: FIFO depth is 2**DEPTH_LOG2 events; legal range 1..6.
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset (driven from KEY[0]).
- rx_data  in  8  byte from PS/2 controller.
- rx_valid  in  1  one-cycle strobe qualifying rx_data; may assert every cycle.
- evt_code  out  8  head event scancode, without prefixes.
- evt_ext  out  1  head event had E0 prefix.
- evt_break  out  1  head event is a release (F0 seen).
- evt_valid  out  1  FIFO not empty; evt_* are valid.
- evt_ready  in  1  consumer accepts head; pop when evt_valid && evt_ready.
- count  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
- overflow  out  1  sticky: an event was dropped because FIFO was full.
- clear_ovf  in  1  synchronous clear of overflow.
- last_code  out  8  code of most recent decoded make event.

## Operation
- Decoder FSM, states IDLE, E0, F0, E0F0, SKIP; advances only on rx_valid.
- IDLE: E0 -> E0; F0 -> F0; E1 -> SKIP, skip counter = 7; AA/FA/EE/FC/FD/00/FF dropped, stay; other byte -> emit make {ext=0, brk=0}.
- E0: F0 -> E0F0; E0 -> stay in E0; other -> emit make {ext=1}, -> IDLE.
- F0: any byte -> emit break {ext=0}, -> IDLE.
- E0F0: any byte -> emit break {ext=1}, -> IDLE.
- SKIP: each byte decrements counter; counter reaching 0 -> IDLE; no event emitted (pause key is discarded).
- Emit = push {code, ext, brk} into FIFO. last_code updates on every emitted make, regardless of FIFO space.
- FIFO: circular, write/read pointers of DEPTH_LOG2+1 bits; full when pointer MSBs differ and rest equal.
- Push when not full. Push while full with a pop in the same cycle is accepted (count unchanged). Push while full without pop: event dropped, overflow set.
- Pop on empty is ignored. Simultaneous push and pop on empty: push lands; evt_valid rises next cycle.
- overflow: set wins over clear_ovf in the same cycle.

## Timing
- Reset values: FSM IDLE, skip counter 0, pointers 0, count 0, evt_valid 0, evt_code/ext/break 0, overflow 0, last_code 8'h00.
- Latency: rx_valid at edge N completing an event -> evt_valid=1 and evt_* valid after edge N (visible in cycle N+1) when FIFO empty.
- Pop at edge M -> next head (or evt_valid=0) visible after edge M.
- count and evt_valid are registered; no combinational path from rx_valid or evt_ready to any output.
- resetn assertion mid-sequence (e.g. after E0) discards partial prefix and all buffered events immediately.

## Configuration
- PS2_TYPEMATIC_FILTER_EN defined: block holds one {code, ext} of the currently held key plus held flag; a make identical to the held key while held is suppressed (no push, last_code unchanged); any other make replaces held; a break matching held clears the flag. Reset clears the flag.
- Not defined: every decoded make is pushed, typematic repeats included; no held register is built.

## Test plan
- Bytes 1C, F0 1C -> events {1C,ext0,brk0}, {1C,ext0,brk1}; last_code=1C; count=2 before popping.
- Bytes E0 75, E0 F0 75 -> {75,ext1,brk0}, {75,ext1,brk1}.
- Bytes E1 14 77 E1 F0 14 F0 77 then 29 -> only {29,0,0} emitted; FSM IDLE afterwards.
- DEPTH_LOG2=3, evt_ready=0, push 9 makes -> count=8, overflow=1, 9th dropped; pop all yields first 8 in order; clear_ovf -> overflow=0.
- Full FIFO, push and pop same cycle -> count stays 8, overflow stays 0, new event appears last.
- With PS2_TYPEMATIC_FILTER_EN: 1C 1C 1C F0 1C 1C -> {1C make}, {1C break}, {1C make}; without the macro: five events.
